// File: rtl/irq_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// irq_arbiter: fixed-priority share of one CPU irq/eoi handshake among
// N_SRC interrupt sources, with ENABLE/PENDING/ACTIVE/SVC_COUNT registers.
// Revision: 1.0
// ------------------------------------------------------------------------
module irq_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             sel_i,
  input  logic             wr_en_i,
  input  logic [11:0]      address_in_i,
  input  logic [31:0]      data_in_i,
  output logic [31:0]      data_out_o,
  output logic             ack_o,
  input  logic [N_SRC-1:0] src_irq_i,
  output logic [N_SRC-1:0] src_eoi_o,
  output logic             cpu_irq_o,
  input  logic             cpu_eoi_i
);

  localparam logic [11:0] ADDR_ENABLE  = 12'h000;
  localparam logic [11:0] ADDR_PENDING = 12'h004;
  localparam logic [11:0] ADDR_ACTIVE  = 12'h008;
  localparam logic [11:0] ADDR_COUNT   = 12'h00C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    SERVICE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [N_SRC-1:0] enable;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] active_mask;
  logic [4:0]       active_id;
  logic [4:0]       winner;
  logic [31:0]      svc_count;
  logic [31:0]      read_data;
  logic             grant;
  logic             complete;
  logic             active_irq;
  logic             in_service;
  logic             unused_data;

  assign eligible    = src_irq_i & enable;
  assign unused_data = ^data_in_i;

  // Scanning downward leaves the lowest set index as the winner.
  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 5'(i);
    end
  end

  always_comb begin
    active_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      active_mask[i] = (active_id == 5'(i));
    end
  end

  assign active_irq = |(src_irq_i & active_mask);

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_eoi_i && (eligible != '0)) begin
          state_next = GRANT;
          grant      = 1'b1;
        end
      end
      GRANT: begin
        if (!cpu_eoi_i) state_next = SERVICE;
      end
      SERVICE: begin
        if (cpu_eoi_i) begin
          state_next = DRAIN;
          complete   = 1'b1;
        end
      end
      DRAIN: begin
        // Wait for the serviced source to withdraw so it is not re-granted.
        if (!active_irq) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      active_id <= '0;
      svc_count <= '0;
    end else begin
      state <= state_next;
      if (grant)    active_id <= winner;
      if (complete) svc_count <= svc_count + 32'd1;
    end
  end

  // Handshake outputs decode straight from the state so reset clears them at once.
  assign in_service = (state == SERVICE);
  assign cpu_irq_o  = (state == GRANT) || in_service;
  assign src_eoi_o  = in_service ? ~active_mask : '1;

  always_comb begin
    read_data = '0;
    case (address_in_i)
      ADDR_ENABLE:  read_data[N_SRC-1:0] = enable;
      ADDR_PENDING: read_data[N_SRC-1:0] = eligible;
      ADDR_ACTIVE: begin
        read_data[31]  = cpu_irq_o;
        read_data[4:0] = active_id;
      end
      ADDR_COUNT:   read_data = svc_count;
      default:      read_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      ack_o      <= 1'b0;
      data_out_o <= '0;
      enable     <= '0;
    end else begin
      ack_o      <= sel_i;
      data_out_o <= (sel_i && !wr_en_i) ? read_data : '0;
      if (sel_i && wr_en_i && (address_in_i == ADDR_ENABLE)) begin
        enable <= data_in_i[N_SRC-1:0];
      end
    end
  end

endmodule
`default_nettype wire
